mem_stage_access_unit: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns the latched ALU result, store data and MemRead/MemWrite controls into transactions on a multi-cycle data-memory req/ack interface.
- Stalls the upstream pipeline while an access is outstanding.
- Presents registered load data, ALU result and write-back select to the MEM/WB register.

---
 rtl/mem_stage_pkg.sv | 14 +
 rtl/mem_timeout_counter.sv | 38 +++
 rtl/mem_stage_access_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_stage_access_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage access unit.
// State encoding, default timeout, and the word-alignment mask.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_e;

    localparam int         DEFAULT_TIMEOUT = 255;
    localparam logic [1:0] ALIGN_MASK      = 2'b11;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts ACCESS cycles; expired is high on the cycle the count reaches TIMEOUT-1.
// Zero latency from count to expired; clear has priority over enable.
module mem_timeout_counter
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM stage: turns EX/MEM memory controls into req/ack transactions and feeds MEM/WB.
// Non-memory ops take one cycle; memory ops stall upstream from IDLE through ACCESS.
module mem_stage_access_unit
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int TIMEOUT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_Valid,
    input  logic [DATA_WIDTH-1:0] in_ALUResult,
    input  logic [DATA_WIDTH-1:0] in_ReadData2,
    input  logic                  in_CtrlMemRead,
    input  logic                  in_CtrlMemWrite,
    input  logic                  in_CtrlALUOrMem,
    output logic                  out_Stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_Valid,
    output logic [DATA_WIDTH-1:0] out_ReadData,
    output logic [DATA_WIDTH-1:0] out_ALUResult,
    output logic                  out_CtrlALUOrMem,
    output logic                  out_Error
);

    state_e                state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_read_data_q, out_read_data_d;
    logic [DATA_WIDTH-1:0] out_alu_result_q, out_alu_result_d;
    logic                  out_ctrl_q, out_ctrl_d;
    logic                  out_error_q, out_error_d;

    logic memop;
    logic misaligned;
    logic cnt_clear;
    logic cnt_en;
    logic cnt_expired;

    assign memop      = in_Valid & (in_CtrlMemRead | in_CtrlMemWrite);
    assign misaligned = |(in_ALUResult[1:0] & ALIGN_MASK);

    mem_timeout_counter #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (cnt_expired)
    );

    always_comb begin
        state_d          = state_q;
        mem_req_d        = mem_req_q;
        mem_we_d         = mem_we_q;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        out_valid_d      = out_valid_q;
        out_read_data_d  = out_read_data_q;
        out_alu_result_d = out_alu_result_q;
        out_ctrl_d       = out_ctrl_q;
        out_error_d      = out_error_q;
        cnt_clear        = 1'b0;
        cnt_en           = 1'b0;

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (memop) begin
                    out_alu_result_d = in_ALUResult;
                    out_ctrl_d       = in_CtrlALUOrMem;
                    if (misaligned) begin
                        out_error_d     = 1'b1;
                        out_valid_d     = 1'b1;
                        out_read_data_d = '0;
                        state_d         = COMPLETE;
                    end else begin
                        // A set MemRead wins over MemWrite, so both-set is a load.
                        mem_req_d   = 1'b1;
                        mem_we_d    = !in_CtrlMemRead;
                        mem_addr_d  = in_ALUResult;
                        mem_wdata_d = in_ReadData2;
                        cnt_clear   = 1'b1;
                        state_d     = ACCESS;
                    end
                end else if (in_Valid) begin
                    out_valid_d      = 1'b1;
                    out_alu_result_d = in_ALUResult;
                    out_ctrl_d       = in_CtrlALUOrMem;
                    out_read_data_d  = '0;
                end
            end
            ACCESS: begin
                cnt_en = 1'b1;
                if (mem_ack) begin
                    mem_req_d       = 1'b0;
                    out_read_data_d = mem_we_q ? '0 : mem_rdata;
                    out_valid_d     = 1'b1;
                    state_d         = COMPLETE;
                end else if (cnt_expired) begin
                    mem_req_d       = 1'b0;
                    out_error_d     = 1'b1;
                    out_read_data_d = '0;
                    out_valid_d     = 1'b1;
                    state_d         = COMPLETE;
                end
            end
            COMPLETE: begin
                // Inputs still hold the finished instruction here; ignore them.
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            mem_req_q        <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            out_valid_q      <= 1'b0;
            out_read_data_q  <= '0;
            out_alu_result_q <= '0;
            out_ctrl_q       <= 1'b0;
            out_error_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            mem_req_q        <= mem_req_d;
            mem_we_q         <= mem_we_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
            out_valid_q      <= out_valid_d;
            out_read_data_q  <= out_read_data_d;
            out_alu_result_q <= out_alu_result_d;
            out_ctrl_q       <= out_ctrl_d;
            out_error_q      <= out_error_d;
        end
    end

    // Gated by reset so the pipeline is never held while the unit is in reset.
    assign out_Stall = reset & (((state_q == IDLE) & memop) | (state_q == ACCESS));

    assign mem_req          = mem_req_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
    assign out_Valid        = out_valid_q;
    assign out_ReadData     = out_read_data_q;
    assign out_ALUResult    = out_alu_result_q;
    assign out_CtrlALUOrMem = out_ctrl_q;
    assign out_Error        = out_error_q;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Bench for mem_stage_access_unit: scenario tasks plus a scoreboard of MEM/WB payloads.
module tb_mem_stage_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_Valid;
    logic [31:0] in_ALUResult;
    logic [31:0] in_ReadData2;
    logic        in_CtrlMemRead;
    logic        in_CtrlMemWrite;
    logic        in_CtrlALUOrMem;
    logic        out_Stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_Valid;
    logic [31:0] out_ReadData;
    logic [31:0] out_ALUResult;
    logic        out_CtrlALUOrMem;
    logic        out_Error;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] alu;
        logic        wb;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mem_stage_access_unit #(
        .DATA_WIDTH (32),
        .TIMEOUT    (4),
        .TIMEOUT_W  (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_Valid         (in_Valid),
        .in_ALUResult     (in_ALUResult),
        .in_ReadData2     (in_ReadData2),
        .in_CtrlMemRead   (in_CtrlMemRead),
        .in_CtrlMemWrite  (in_CtrlMemWrite),
        .in_CtrlALUOrMem  (in_CtrlALUOrMem),
        .out_Stall        (out_Stall),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .out_Valid        (out_Valid),
        .out_ReadData     (out_ReadData),
        .out_ALUResult    (out_ALUResult),
        .out_CtrlALUOrMem (out_CtrlALUOrMem),
        .out_Error        (out_Error)
    );

    // Scoreboard: every MEM/WB pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (reset && out_Valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out_valid alu=%h rd=%h", out_ALUResult, out_ReadData);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_ReadData !== mon_e.rdata || out_ALUResult !== mon_e.alu ||
                    out_CtrlALUOrMem !== mon_e.wb || out_Error !== mon_e.err) begin
                    bad++;
                    $display("FAIL payload got rd=%h alu=%h wb=%b err=%b want rd=%h alu=%h wb=%b err=%b",
                             out_ReadData, out_ALUResult, out_CtrlALUOrMem, out_Error,
                             mon_e.rdata, mon_e.alu, mon_e.wb, mon_e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [31:0] rdata, input logic [31:0] alu,
                                input logic wb, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.alu   = alu;
        e.wb    = wb;
        e.err   = err;
        return e;
    endfunction

    // Presents one memory instruction at a negedge, acts as the memory, and holds the
    // instruction until the stall drops. ack_at = ACCESS cycle carrying mem_ack (0 = never).
    task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic rd, input logic wr, input logic wb,
                             input int ack_at, input logic [31:0] rdata, input bit hold_in,
                             output int sc, output int rc, output int bad_hold,
                             output bit hung, output bit req_after);
        in_Valid        = 1'b1;
        in_ALUResult    = addr;
        in_ReadData2    = wdata;
        in_CtrlMemRead  = rd;
        in_CtrlMemWrite = wr;
        in_CtrlALUOrMem = wb;
        mem_ack         = 1'b0;
        mem_rdata       = 32'h0;
        sc = 0; rc = 0; bad_hold = 0; hung = 1'b1; req_after = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!out_Stall) begin
                hung = 1'b0;
                break;
            end
            sc++;
            @(posedge clk);
            @(negedge clk);
            if (mem_req) begin
                rc++;
                if (mem_we !== !rd || mem_addr !== addr || mem_wdata !== wdata) bad_hold++;
                if (rc == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'h0;
            end
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        if (!hold_in) in_Valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_after       = mem_req;
        in_Valid        = 1'b0;
        in_CtrlMemRead  = 1'b0;
        in_CtrlMemWrite = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        in_Valid       = 1'b1;
        in_CtrlMemRead = 1'b1;
        in_ALUResult   = 32'h40;
        #1;
        total++;
        if (out_Stall !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", out_Stall); end
        total++;
        if (mem_req !== 1'b0 || out_Valid !== 1'b0) begin
            bad++; $display("FAIL reset_req_valid got req=%b vld=%b want 0 0", mem_req, out_Valid);
        end
        total++;
        if (out_Error !== 1'b0 || out_ReadData !== 32'h0 || out_ALUResult !== 32'h0) begin
            bad++; $display("FAIL reset_regs got err=%b rd=%h alu=%h want 0", out_Error, out_ReadData, out_ALUResult);
        end
        @(negedge clk);
        in_Valid       = 1'b0;
        in_CtrlMemRead = 1'b0;
        reset          = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu_op();
        in_Valid        = 1'b1;
        in_ALUResult    = 32'h0000_00A5;
        in_CtrlALUOrMem = 1'b1;
        mem_ack         = 1'b1;
        mem_rdata       = 32'hFFFF_FFFF;
        exp_q.push_back(mk(32'h0, 32'hA5, 1'b1, 1'b0));
        #1;
        total++;
        if (out_Stall !== 1'b0) begin bad++; $display("FAIL alu_stall got %b want 0", out_Stall); end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (out_Valid !== 1'b1 || mem_req !== 1'b0) begin
            bad++; $display("FAIL alu_valid got vld=%b req=%b want 1 0", out_Valid, mem_req);
        end
        in_Valid = 1'b0;
        mem_ack  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (out_Valid !== 1'b0) begin bad++; $display("FAIL alu_valid_drop got %b want 0", out_Valid); end
    endtask

    task automatic test_load();
        int sc, rc, bh; bit hung, ra;
        exp_q.push_back(mk(32'hDEAD_BEEF, 32'h10, 1'b0, 1'b0));
        do_access(32'h10, 32'h5555_5555, 1'b1, 1'b0, 1'b0, 3, 32'hDEAD_BEEF, 1'b0, sc, rc, bh, hung, ra);
        total++;
        if (hung || sc !== 4 || rc !== 3 || bh !== 0) begin
            bad++; $display("FAIL load_timing got hung=%b stall=%0d req=%0d badhold=%0d want 0 4 3 0", hung, sc, rc, bh);
        end
    endtask

    task automatic test_store();
        int sc, rc, bh; bit hung, ra;
        exp_q.push_back(mk(32'h0, 32'h20, 1'b1, 1'b0));
        do_access(32'h20, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 1, 32'hFFFF_FFFF, 1'b0, sc, rc, bh, hung, ra);
        total++;
        if (hung || sc !== 2 || rc !== 1 || bh !== 0) begin
            bad++; $display("FAIL store_timing got hung=%b stall=%0d req=%0d badhold=%0d want 0 2 1 0", hung, sc, rc, bh);
        end
        total++;
        if (out_Error !== 1'b0) begin bad++; $display("FAIL store_error got %b want 0", out_Error); end
    endtask

    task automatic test_both_set_and_hold();
        int sc, rc, bh; bit hung, ra;
        // Both controls set is a load; inputs left up in COMPLETE must not start a new access.
        exp_q.push_back(mk(32'hCAFE_0001, 32'h1C, 1'b1, 1'b0));
        do_access(32'h1C, 32'h0BAD_0BAD, 1'b1, 1'b1, 1'b1, 1, 32'hCAFE_0001, 1'b1, sc, rc, bh, hung, ra);
        total++;
        if (hung || sc !== 2 || rc !== 1 || bh !== 0) begin
            bad++; $display("FAIL both_timing got hung=%b stall=%0d req=%0d badhold=%0d want 0 2 1 0", hung, sc, rc, bh);
        end
        total++;
        if (ra !== 1'b0) begin bad++; $display("FAIL complete_ignore got req=%b want 0", ra); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int sc, rc, bh; bit hung, ra;
        exp_q.push_back(mk(32'h0, 32'h100, 1'b0, 1'b0));
        do_access(32'h100, 32'hA5A5_0000, 1'b0, 1'b1, 1'b0, 2, 32'h0, 1'b0, sc, rc, bh, hung, ra);
        total++;
        if (hung || sc !== 3 || rc !== 2 || bh !== 0) begin
            bad++; $display("FAIL b2b_store got hung=%b stall=%0d req=%0d badhold=%0d want 0 3 2 0", hung, sc, rc, bh);
        end
        exp_q.push_back(mk(32'h7777_1111, 32'h104, 1'b1, 1'b0));
        do_access(32'h104, 32'h0, 1'b1, 1'b0, 1'b1, 1, 32'h7777_1111, 1'b0, sc, rc, bh, hung, ra);
        total++;
        if (hung || sc !== 2 || rc !== 1 || bh !== 0) begin
            bad++; $display("FAIL b2b_load got hung=%b stall=%0d req=%0d badhold=%0d want 0 2 1 0", hung, sc, rc, bh);
        end
    endtask

    task automatic test_misaligned();
        int sc, rc, bh; bit hung, ra;
        exp_q.push_back(mk(32'h0, 32'h13, 1'b0, 1'b1));
        do_access(32'h13, 32'h0, 1'b1, 1'b0, 1'b0, 1, 32'hFFFF_FFFF, 1'b0, sc, rc, bh, hung, ra);
        total++;
        if (hung || sc !== 1 || rc !== 0) begin
            bad++; $display("FAIL misaligned_timing got hung=%b stall=%0d req=%0d want 0 1 0", hung, sc, rc);
        end
        total++;
        if (out_Error !== 1'b1) begin bad++; $display("FAIL misaligned_error got %b want 1", out_Error); end
    endtask

    task automatic test_reset_mid_access();
        int sc, rc, bh; bit hung, ra;
        in_Valid       = 1'b1;
        in_ALUResult   = 32'h30;
        in_CtrlMemRead = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || out_Stall !== 1'b1 || out_Error !== 1'b1) begin
            bad++; $display("FAIL pre_reset got req=%b stall=%b err=%b want 1 1 1", mem_req, out_Stall, out_Error);
        end
        @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || out_Valid !== 1'b0 || out_Stall !== 1'b0 || out_Error !== 1'b0) begin
            bad++; $display("FAIL async_reset got req=%b vld=%b stall=%b err=%b want 0 0 0 0",
                            mem_req, out_Valid, out_Stall, out_Error);
        end
        in_Valid       = 1'b0;
        in_CtrlMemRead = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (mem_req !== 1'b0 || out_Valid !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle got req=%b vld=%b want 0 0", mem_req, out_Valid);
        end
        exp_q.push_back(mk(32'h600D_F00D, 32'h34, 1'b1, 1'b0));
        do_access(32'h34, 32'h0, 1'b1, 1'b0, 1'b1, 2, 32'h600D_F00D, 1'b0, sc, rc, bh, hung, ra);
        total++;
        if (hung || sc !== 3 || rc !== 2 || bh !== 0) begin
            bad++; $display("FAIL post_reset_load got hung=%b stall=%0d req=%0d badhold=%0d want 0 3 2 0", hung, sc, rc, bh);
        end
    endtask

    task automatic test_timeout();
        int sc, rc, bh; bit hung, ra;
        exp_q.push_back(mk(32'h0, 32'h44, 1'b0, 1'b1));
        do_access(32'h44, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0, sc, rc, bh, hung, ra);
        total++;
        if (hung || sc !== 5 || rc !== 4 || bh !== 0) begin
            bad++; $display("FAIL timeout_timing got hung=%b stall=%0d req=%0d badhold=%0d want 0 5 4 0", hung, sc, rc, bh);
        end
        // Error must survive a subsequent successful access.
        exp_q.push_back(mk(32'h0000_ABCD, 32'h48, 1'b0, 1'b1));
        do_access(32'h48, 32'h0, 1'b1, 1'b0, 1'b0, 1, 32'h0000_ABCD, 1'b0, sc, rc, bh, hung, ra);
        total++;
        if (out_Error !== 1'b1) begin bad++; $display("FAIL error_sticky got %b want 1", out_Error); end
    endtask

    initial begin
        reset           = 1'b0;
        in_Valid        = 1'b0;
        in_ALUResult    = 32'h0;
        in_ReadData2    = 32'h0;
        in_CtrlMemRead  = 1'b0;
        in_CtrlMemWrite = 1'b0;
        in_CtrlALUOrMem = 1'b0;
        mem_ack         = 1'b0;
        mem_rdata       = 32'h0;

        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_both_set_and_hold();
        test_back_to_back();
        test_misaligned();
        test_reset_mid_access();
        test_timeout();

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
